// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Provides the anode encodings, the arbiter state enum and small
// digit-selection helpers used by display_arbiter.
package display_pkg;

  localparam int NDIGITS = 4;

  typedef logic [3:0] an_t;

  localparam an_t AN_D0  = 4'b1110;
  localparam an_t AN_D1  = 4'b1101;
  localparam an_t AN_D2  = 4'b1011;
  localparam an_t AN_D3  = 4'b0111;
  localparam an_t AN_OFF = 4'b1111;

  typedef enum logic [1:0] {IDLE, ARB, SHOW} arb_state_t;

  // Active-low anode pattern for a scan index.
  function automatic an_t digit_anode(input logic [1:0] idx);
    an_t a;
    case (idx)
      2'd0:    a = AN_D0;
      2'd1:    a = AN_D1;
      2'd2:    a = AN_D2;
      default: a = AN_D3;
    endcase
    return a;
  endfunction

  // Nibble of a 16-bit value shown on a given scan index.
  function automatic logic [3:0] digit_nibble(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

  // A digit is significant if it or anything above it is non-zero;
  // digit 0 always counts so a zero value still shows "0".
  function automatic logic digit_significant(input logic [15:0] v, input logic [1:0] idx);
    logic s;
    case (idx)
      2'd0:    s = 1'b1;
      2'd1:    s = |v[15:4];
      2'd2:    s = |v[15:8];
      default: s = |v[15:12];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Requester/display bus for display_arbiter.
// master: the requester side (drives req/value, sees grant/done/owner and
// the display pins). slave: the arbiter.
interface display_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   value;
  logic [NREQ-1:0]      grant;
  logic                 done;
  logic [OW-1:0]        owner;
  logic [3:0]           an;
  logic [3:0]           digit;

  modport master (output req, value, input grant, done, owner, an, digit);
  modport slave  (input req, value, output grant, done, owner, an, digit);
endinterface

// File: rtl/display_arbiter_scan_timer.sv
// Digit-scan timebase: prescaler of SCAN_DIV clocks per digit, a 2-bit
// digit index, and per-digit / per-frame tick strobes.
module scan_timer #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       dtick_o,
  output logic       ftick_o,
  output logic [1:0] index_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;

  assign dtick_o = (cnt_q == CNT_LAST);
  assign ftick_o = dtick_o && (idx_q == 2'd3);
  assign index_o = idx_q;

  // Prescaler wraps at SCAN_DIV-1; index advances once per digit period.
  always_comb begin
    cnt_d = dtick_o ? '0 : cnt_q + CW'(1);
    idx_d = dtick_o ? idx_q + 2'd1 : idx_q;
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit 7-segment display,
// with a minimum hold of HOLD_FRAMES scan frames per owner. Drives the
// active-low anodes and the nibble of the lit digit; the hex decoder sits
// downstream. Optional build macro LZ_BLANK_EN blanks leading-zero digits.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic             clk,
  input  logic             reset,
  display_arbiter_if.slave bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [15:0]     disp_q, disp_d;
  logic            done_q, done_d;
  an_t             an_q, an_d;
  logic [3:0]      digit_q, digit_d;

  // dtick is left for other consumers of the timebase; only frames matter here.
  logic            scan_dtick_unused;
  logic            ftick;
  logic [1:0]      scan_idx;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic [15:0]     win_val;
  logic            own_req;
  logic [15:0]     own_val;
  logic            others;
  logic            hold_done;
  logic            lit;

  scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .dtick_o (scan_dtick_unused),
    .ftick_o (ftick),
    .index_o (scan_idx)
  );

  // Round-robin pick: first requester above the last owner, wrapping.
  always_comb begin
    int c;
    c         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_val   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = int'(rr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!win_found && bus.req[c[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = c[OW-1:0];
        win_val   = bus.value[16*c +: 16];
      end
    end
  end

  // Current owner's live request and value.
  always_comb begin
    own_req = 1'b0;
    own_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == owner_q) begin
        own_req = bus.req[i];
        own_val = bus.value[16*i +: 16];
      end
    end
  end

  assign others    = |(bus.req & ~grant_q);
  assign hold_done = (hold_q == HOLD_MAX);

  // Arbiter next state: grant in ARB, hold/release/refresh in SHOW.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) state_d = ARB;
      end
      ARB: begin
        if (win_found) begin
          state_d          = SHOW;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          rr_d             = win_idx;
          disp_d           = win_val;
          hold_d           = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        // Owner leaving always wins; preemption only once the hold expired.
        if (!own_req || (hold_done && others)) begin
          grant_d = '0;
          done_d  = 1'b1;
          state_d = (|bus.req) ? ARB : IDLE;
        end else if (ftick) begin
          if (hold_done) disp_d = own_val;
          else           hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display drive follows the next state so release blanks on the same edge.
`ifdef LZ_BLANK_EN
  assign lit = digit_significant(disp_d, scan_idx);
`else
  assign lit = 1'b1;
`endif

  // Anode/nibble selection for the current scan index.
  always_comb begin
    an_d    = AN_OFF;
    digit_d = '0;
    if (state_d == SHOW && lit) begin
      an_d    = digit_anode(scan_idx);
      digit_d = digit_nibble(disp_d, scan_idx);
    end
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= OW'(NREQ - 1);
      hold_q  <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
      an_q    <= AN_OFF;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.owner = owner_q;
  assign bus.an    = an_q;
  assign bus.digit = digit_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter (NREQ=4, SCAN_DIV=4, HOLD_FRAMES=2): a vector
// table of first-grant cases, hand sequences for multi-cycle corners and a
// random run, all compared cycle by cycle against a behavioural model.
module tb_display_arbiter;
  localparam int NREQ = 4;
  localparam int SD   = 4;
  localparam int HF   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  display_arbiter_if #(.NREQ(NREQ)) bus();

  display_arbiter #(.NREQ(NREQ), .SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycle count since reset drives the scan.
  int         m_n, m_st, m_rr, m_own, m_hold;
  logic [15:0] m_disp;
  logic [3:0] e_grant, e_an, e_digit;
  logic       e_done;
  logic [1:0] e_owner;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_lit(input logic [15:0] v, input int idx);
`ifdef LZ_BLANK_EN
    return (idx == 0) || ((v >> (4*idx)) != 16'd0);
`else
    return (v == v) || (idx >= 0);
`endif
  endfunction

  // One clock edge of the reference behaviour; m_st: 0 idle, 1 arbitrate, 2 show.
  task automatic model_edge(input logic [3:0] r, input logic [63:0] v, input logic rst);
    int idx, c;
    bit ft, held, oth, found;
    if (rst) begin
      m_n = 0; m_st = 0; m_rr = NREQ-1; m_own = 0; m_hold = 0; m_disp = 0;
      e_grant = 0; e_done = 0; e_owner = 0; e_an = 4'hF; e_digit = 0;
      return;
    end
    idx = (m_n / SD) % 4;
    ft  = (m_n % (4*SD)) == (4*SD - 1);
    e_done = 0;
    if (m_st == 0) begin
      if (r != 0) m_st = 1;
    end else if (m_st == 1) begin
      if (r == 0) m_st = 0;
      else begin
        found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_rr + k) % NREQ;
          if (!found && r[c[1:0]]) begin found = 1; m_own = c; end
        end
        m_rr = m_own; e_grant = 4'(1 << m_own); e_owner = 2'(m_own);
        m_disp = v[16*m_own +: 16]; m_hold = 0; m_st = 2;
      end
    end else begin
      held = (m_hold >= HF);
      oth  = (r & ~(4'(1 << m_own))) != 0;
      if (!r[m_own] || (held && oth)) begin
        e_grant = 0; e_done = 1; m_st = (r != 0) ? 1 : 0;
      end else if (ft) begin
        if (held) m_disp = v[16*m_own +: 16];
        else      m_hold++;
      end
    end
    e_an = 4'hF; e_digit = 0;
    if (m_st == 2 && model_lit(m_disp, idx)) begin
      e_an    = ~(4'(1 << idx));
      e_digit = m_disp[4*idx +: 4];
    end
    m_n++;
  endtask

  task automatic tick();
    logic [31:0] a, e;
    @(posedge clk);
    model_edge(bus.req, bus.value, reset);
    #1;
    a = {17'd0, bus.grant, bus.done, bus.owner, bus.an, bus.digit};
    e = {17'd0, e_grant, e_done, e_owner, e_an, e_digit};
    check("cycle_model", a, e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit seen);
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      if (bus.done) seen = 1;
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [3:0] an;
    logic [3:0] digit;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit seen, any_done;
    logic [3:0] an_seen;
    logic [3:0] d0;

    bus.req = '0;
    bus.value = '0;

    vt[0] = '{4'b0001, 4'b0001, 2'd0, 4'b1110, 4'h1};
    vt[1] = '{4'b0101, 4'b0001, 2'd0, 4'b1110, 4'h1};
    vt[2] = '{4'b1000, 4'b1000, 2'd3, 4'b1110, 4'h4};
    vt[3] = '{4'b0110, 4'b0010, 2'd1, 4'b1110, 4'h2};
    vt[4] = '{4'b1100, 4'b0100, 2'd2, 4'b1110, 4'h3};
    vt[5] = '{4'b0000, 4'b0000, 2'd0, 4'b1111, 4'h0};

    do_reset();
    check("reset_state", {17'd0, bus.grant, bus.done, bus.owner, bus.an, bus.digit},
          {17'd0, 4'b0000, 1'b0, 2'd0, 4'b1111, 4'h0});

    // First grant from reset: lowest set bit wins, two edges after req.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.value = 64'h4444_3333_2222_1111;
      bus.req   = vt[i].req;
      tick(); tick();
      check("first_grant", {16'd0, bus.grant, bus.owner, bus.an, bus.digit, bus.done},
            {16'd0, vt[i].grant, vt[i].owner, vt[i].an, vt[i].digit, 1'b0});
    end

    // Single request BEEF: digit sequence F,E,E,B over one frame; no done.
    do_reset();
    bus.value = 64'h0000_0000_0000_BEEF;
    bus.req = 4'b0001;
    any_done = 0;
    repeat (40) begin
      tick();
      if (bus.done) any_done = 1;
    end
    check("single_no_done", {31'd0, any_done}, 32'd0);

    // Contention 0101: owner 0, then 2 after hold, then back to 0.
    do_reset();
    bus.value = 64'h4444_3333_2222_1111;
    bus.req = 4'b0101;
    tick(); tick();
    check("cont_first", {28'd0, bus.grant}, {28'd0, 4'b0001});
    wait_done(64, seen);
    check("cont_done1", {31'd0, seen}, 32'd1);
    check("cont_gap", {28'd0, bus.grant}, 32'd0);
    tick();
    check("cont_second", {28'd0, bus.grant}, {28'd0, 4'b0100});
    wait_done(64, seen);
    check("cont_done2", {31'd0, seen}, 32'd1);
    tick();
    check("cont_third", {28'd0, bus.grant}, {28'd0, 4'b0001});

    // Early drop by owner 2 before the hold expires.
    do_reset();
    bus.req = 4'b0100;
    tick(); tick();
    repeat (5) tick();
    bus.req = 4'b0000;
    tick();
    check("drop_done_an", {27'd0, bus.done, bus.an}, {27'd0, 1'b1, 4'b1111});
    tick();
    check("drop_idle", {27'd0, bus.done, bus.grant}, 32'd0);

    // Extended sole ownership with live value refresh.
    do_reset();
    bus.value = 64'h0000_0000_1234_0000;
    bus.req = 4'b0010;
    any_done = 0;
    tick(); tick();
    repeat (40) begin tick(); if (bus.done) any_done = 1; end
    bus.value = 64'h0000_0000_5678_0000;
    seen = 0;
    repeat (56) begin
      tick();
      if (bus.done) any_done = 1;
      if (bus.an == 4'b1110 && bus.digit == 4'h8) seen = 1;
    end
    check("ext_refresh", {31'd0, seen}, 32'd1);
    check("ext_kept", {27'd0, any_done, bus.grant}, {27'd0, 1'b0, 4'b0010});

    // Reset while showing, then scan restarts from digit 0.
    do_reset();
    check("midreset", {17'd0, bus.grant, bus.done, bus.owner, bus.an, bus.digit},
          {17'd0, 4'b0000, 1'b0, 2'd0, 4'b1111, 4'h0});
    tick(); tick();
    check("restart_idx", {22'd0, bus.an, bus.grant, bus.owner},
          {22'd0, 4'b1110, 4'b0010, 2'd1});

    // Leading-zero blanking on 0x0070.
    do_reset();
    bus.value = 64'h0000_0000_0000_0070;
    bus.req = 4'b0001;
    an_seen = 0;
    d0 = 4'hF;
    repeat (40) begin
      tick();
      for (int k = 0; k < 4; k++)
        if (bus.an == ~(4'(1 << k))) an_seen[k] = 1'b1;
      if (bus.an == 4'b1110) d0 = bus.digit;
    end
`ifdef LZ_BLANK_EN
    check("lz_anodes", {28'd0, an_seen}, {28'd0, 4'b0011});
`else
    check("lz_anodes", {28'd0, an_seen}, {28'd0, 4'b1111});
`endif
    check("lz_digit0", {28'd0, d0}, 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) bus.req = 4'($urandom);
      if ($urandom_range(15) == 0) bus.value = {$urandom, $urandom};
      reset = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
